// File: rtl/periph_hub_if.sv
// Bus bundle for periph_hub: byte channels in, CPU presentation and LED write paths.
// The hub takes the slave modport; the environment (sources plus CPU) takes master.
interface periph_hub_if #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 8
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*DATA_W-1:0] in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic                  int0;
  logic [DATA_W-1:0]     cpu_rd_data;
  logic [CHW-1:0]        cpu_rd_ch;
  logic                  cpu_read_end;
  logic                  cpu_wr;
  logic [OUT_W-1:0]      cpu_wr_data;
  logic [OUT_W-1:0]      leds;
  logic                  leds_upd;

  modport master (
    output in_data, in_valid, cpu_read_end, cpu_wr, cpu_wr_data,
    input  in_ready, int0, cpu_rd_data, cpu_rd_ch, leds, leds_upd
  );

  modport slave (
    input  in_data, in_valid, cpu_read_end, cpu_wr, cpu_wr_data,
    output in_ready, int0, cpu_rd_data, cpu_rd_ch, leds, leds_upd
  );
endinterface

// File: rtl/periph_hub.sv
// Peripheral hub: per-channel byte FIFOs, a round-robin presenter that interrupts the CPU
// once per byte, and an independent CPU-written LED register with an update pulse.
module periph_hub #(
  parameter int unsigned NCH    = 2,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned OUT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  periph_hub_if.slave bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;

  typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

  state_e state_q, state_d;

  logic [NCH-1:0][AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [NCH-1:0][CW-1:0] count_q;
  logic [DATA_W-1:0]      mem_q [NCH][DEPTH];

  logic [NCH-1:0] ready, push, pop, nonempty;
  logic [CHW-1:0] rr_q, grant, cand;
  logic           grant_valid;
  logic           load, pop_en;

  logic              int0_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [CHW-1:0]    rd_ch_q;
  logic [OUT_W-1:0]  leds_q;
  logic              leds_upd_q;

  always_comb begin
    ready    = '0;
    push     = '0;
    pop      = '0;
    nonempty = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      ready[c]    = (count_q[c] != CW'(DEPTH));
      nonempty[c] = (count_q[c] != '0);
      push[c]     = bus.in_valid[c] & ready[c];
      // Only the channel currently presented can be popped.
      pop[c]      = pop_en & (rd_ch_q == CHW'(c));
    end
  end

  // Round robin: first non-empty channel strictly after the last-served one.
  always_comb begin
    grant_valid = 1'b0;
    grant       = rr_q;
    cand        = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = CHW'((32'(rr_q) + i) % NCH);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StPresent;
          load    = 1'b1;
        end
      end
      StPresent: begin
        if (bus.cpu_read_end) begin
          state_d = StGap;
          pop_en  = 1'b1;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= CHW'(NCH - 1);
      int0_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_ch_q    <= '0;
      leds_q     <= '0;
      leds_upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned c = 0; c < NCH; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
        count_q[c] <= count_q[c] + CW'(push[c]) - CW'(pop[c]);
      end
      int0_q <= (state_d == StPresent);
      if (load) begin
        rd_data_q <= mem_q[grant][rd_ptr_q[grant]];
        rd_ch_q   <= grant;
      end
      if (pop_en) rr_q <= rd_ch_q;
      if (bus.cpu_wr) leds_q <= bus.cpu_wr_data;
      leds_upd_q <= bus.cpu_wr;
    end
  end

  // Storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NCH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.in_data[c*DATA_W +: DATA_W];
    end
  end

  assign bus.in_ready    = ready;
  assign bus.int0        = int0_q;
  assign bus.cpu_rd_data = rd_data_q;
  assign bus.cpu_rd_ch   = rd_ch_q;
  assign bus.leds        = leds_q;
  assign bus.leds_upd    = leds_upd_q;
endmodule

// File: tb/tb_periph_hub.sv
// Scoreboard bench for periph_hub: byte sources and a CPU model drive the hub; a negedge
// monitor checks presentations, backpressure and LED updates against queue-based expectations.
module tb_periph_hub;
  localparam int unsigned NCH    = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned OUT_W  = 8;

  logic clk;
  logic rst;

  periph_hub_if #(.NCH(NCH), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  periph_hub #(.NCH(NCH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Edge counter since reset release; edge 1 is the first active edge.
  int cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Expected-response queues: bytes tagged with the edge they were accepted on; LED writes.
  typedef struct packed {
    logic [31:0]       tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t             mq [NCH][$];
  logic [OUT_W-1:0] led_q [$];

  bit                presenting;
  int                pres_ch;
  int                rr;
  int                ready_edge;
  logic [DATA_W-1:0] last_data;
  int                last_ch;
  logic [OUT_W-1:0]  led_model;

  always @(negedge clk) begin
    logic [NCH-1:0] mready;
    bit             found;
    int             ch;
    if (!rst) begin
      chk("rst_outputs", {bus.int0, bus.leds_upd, bus.in_ready},
          {1'b0, 1'b0, {NCH{1'b1}}});
      chk("rst_values", {bus.cpu_rd_data, 7'd0, bus.cpu_rd_ch, bus.leds}, '0);
      for (int c = 0; c < NCH; c++) mq[c].delete();
      led_q.delete();
      presenting = 0;
      pres_ch    = 0;
      rr         = NCH - 1;
      ready_edge = 1;
      last_data  = '0;
      last_ch    = 0;
      led_model  = '0;
    end else begin
      for (int c = 0; c < NCH; c++) mready[c] = (mq[c].size() != DEPTH);
      chk("in_ready", bus.in_ready, mready);

      if (!presenting && cyc >= ready_edge) begin
        found = 0;
        for (int i = 1; i <= NCH; i++) begin
          ch = (rr + i) % NCH;
          if (!found && mq[ch].size() > 0 && mq[ch][0].tag < cyc) begin
            found   = 1;
            pres_ch = ch;
          end
        end
        if (found) begin
          presenting = 1;
          last_data  = mq[pres_ch][0].data;
          last_ch    = pres_ch;
        end
      end
      chk("int0", bus.int0, presenting);
      chk("cpu_rd_data", bus.cpu_rd_data, last_data);
      chk("cpu_rd_ch", bus.cpu_rd_ch, last_ch);

      if (led_q.size() > 0) begin
        chk("leds_upd", bus.leds_upd, 1);
        led_model = led_q.pop_front();
      end else begin
        chk("leds_upd", bus.leds_upd, 0);
      end
      chk("leds", bus.leds, led_model);

      // Inputs now stable take effect on the coming edge cyc+1.
      if (presenting && bus.cpu_read_end) begin
        void'(mq[pres_ch].pop_front());
        rr         = pres_ch;
        presenting = 0;
        ready_edge = cyc + 3;
      end
      for (int c = 0; c < NCH; c++) begin
        if (bus.in_valid[c] && mready[c])
          mq[c].push_back('{tag: 32'(cyc + 1), data: bus.in_data[c*DATA_W +: DATA_W]});
      end
      if (bus.cpu_wr) led_q.push_back(bus.cpu_wr_data);
    end
  end

  // Stimulus side: per-channel pending bytes held until accepted.
  logic [DATA_W-1:0] src_q [NCH][$];
  logic [OUT_W-1:0]  wr_q [$];
  int rd_mode  = 0;  // 0 never, 1 always, 2 random
  bit rnd_push = 0;
  bit rnd_wr   = 0;

  task automatic drive();
    logic [NCH*DATA_W-1:0] d;
    logic [NCH-1:0]        v;
    d = '0;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() > 0) begin
        v[c]                = 1'b1;
        d[c*DATA_W +: DATA_W] = src_q[c][0];
      end
    end
    bus.in_valid = v;
    bus.in_data  = d;
    case (rd_mode)
      1:       bus.cpu_read_end = 1'b1;
      2:       bus.cpu_read_end = ($urandom_range(0, 2) == 0);
      default: bus.cpu_read_end = 1'b0;
    endcase
    if (wr_q.size() > 0) begin
      bus.cpu_wr      = 1'b1;
      bus.cpu_wr_data = wr_q.pop_front();
    end else if (rnd_wr && $urandom_range(0, 3) == 0) begin
      bus.cpu_wr      = 1'b1;
      bus.cpu_wr_data = OUT_W'($urandom);
    end else begin
      bus.cpu_wr      = 1'b0;
      bus.cpu_wr_data = '0;
    end
  endtask

  task automatic step();
    logic [NCH-1:0] acc;
    int             ch;
    @(negedge clk);
    acc = bus.in_valid & bus.in_ready;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++)
      if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    if (rnd_push && $urandom_range(0, 2) == 0) begin
      ch = $urandom_range(0, NCH - 1);
      if (src_q[ch].size() < 3) src_q[ch].push_back(DATA_W'($urandom));
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    bool_wait: begin end
    rst = 1'b0;
    bus.in_valid     = '0;
    bus.in_data      = '0;
    bus.cpu_read_end = 1'b0;
    bus.cpu_wr       = 1'b0;
    bus.cpu_wr_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    run(3);

    // Single byte, then acknowledge.
    src_q[0].push_back(8'hA5);
    rd_mode = 1;
    run(8);

    // Same-cycle pushes on both channels; round robin after ch1 returns to ch0.
    rd_mode = 0;
    src_q[0].push_back(8'h11);
    src_q[1].push_back(8'h22);
    run(4);
    rd_mode = 1;
    run(10);
    rd_mode = 0;
    src_q[0].push_back(8'h33);
    src_q[1].push_back(8'h44);
    run(4);
    rd_mode = 1;
    run(10);

    // Overfill channel 0, then drain.
    rd_mode = 0;
    for (int i = 1; i <= 5; i++) src_q[0].push_back(DATA_W'(i));
    run(10);
    rd_mode = 1;
    run(25);

    // Full FIFO: one pop while the source is still offering.
    rd_mode = 0;
    for (int i = 0; i < 5; i++) src_q[0].push_back(DATA_W'(8'h80 + i));
    run(10);
    rd_mode = 1;
    run(1);
    rd_mode = 0;
    run(3);
    rd_mode = 1;
    run(25);

    // Back-to-back LED writes.
    wr_q.push_back(8'h3C);
    wr_q.push_back(8'hC3);
    run(5);

    // Randomized traffic on all paths.
    rd_mode  = 2;
    rnd_push = 1;
    rnd_wr   = 1;
    run(800);
    rnd_push = 0;
    rnd_wr   = 0;
    rd_mode  = 1;
    run(40);

    // Asynchronous reset while presenting with bytes queued.
    rd_mode = 0;
    src_q[1].push_back(8'hD1);
    src_q[1].push_back(8'hD2);
    src_q[1].push_back(8'hD3);
    sum = 0;
    for (int i = 0; i < 30 && !bus.int0; i++) step();
    run(3);
    chk("wait_present", bus.int0, 1);
    rst = 1'b0;
    #1;
    chk("async_int0", bus.int0, 0);
    chk("async_in_ready", bus.in_ready, {NCH{1'b1}});
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    wr_q.delete();
    bus.in_valid = '0;
    run(2);
    rst = 1'b1;
    rd_mode = 1;
    run(10);
    src_q[1].push_back(8'h5A);
    run(10);

    for (int c = 0; c < NCH; c++) sum += mq[c].size() + src_q[c].size();
    chk("drained", sum, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/periph_hub.md
PERIPH_HUB -- requirements
Module: periph_hub

Interface
REQ-001 Parameter NCH, default 2: number of byte-input peripheral channels, range 1..8.
REQ-002 Parameter DATA_W, default 8: input byte width.
REQ-003 Parameter DEPTH, default 4: per-channel FIFO depth, power of two, at least 2.
REQ-004 Parameter OUT_W, default 8: output (LED) register width.
REQ-005 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port in_data, input, NCH*DATA_W: channel c byte at bits [c*DATA_W +: DATA_W].
REQ-008 Port in_valid, input, NCH: per-channel byte-offer strobe.
REQ-009 Port in_ready, output, NCH: per-channel accept, equal to !full[c].
REQ-010 Port int0, output, 1: CPU interrupt, high while a byte is presented.
REQ-011 Port cpu_rd_data, output, DATA_W: presented byte.
REQ-012 Port cpu_rd_ch, output, max(1,clog2(NCH)): source channel of the presented byte.
REQ-013 Port cpu_read_end, input, 1: CPU acknowledge that the presented byte is consumed.
REQ-014 Port cpu_wr, input, 1: CPU output-register write strobe.
REQ-015 Port cpu_wr_data, input, OUT_W: CPU write data.
REQ-016 Port leds, output, OUT_W: registered output value.
REQ-017 Port leds_upd, output, 1: one-cycle pulse after each leds update.

Function
REQ-018 Each channel has a DEPTH-entry FIFO with a clog2(DEPTH)+1-bit count; a push occurs when in_valid[c] && in_ready[c], and pointers wrap modulo DEPTH.
REQ-019 A push into a full FIFO never occurs, because in_ready[c] is 0 when full; an offered byte remains pending at the source.
REQ-020 A simultaneous push and pop on the same FIFO both take effect: count is unchanged and data order is preserved.
REQ-021 The presenter FSM has three states: IDLE, PRESENT and GAP.
REQ-022 In IDLE with any FIFO non-empty, a round-robin arbiter selects the first non-empty channel after the last-served channel (the pointer resets to NCH-1, so channel 0 is served first); the FSM loads cpu_rd_data and cpu_rd_ch from that FIFO head and enters PRESENT.
REQ-023 In PRESENT, int0 is 1 and cpu_rd_data and cpu_rd_ch are held stable.
REQ-024 In PRESENT, cpu_read_end=1 pops the selected FIFO on that edge, updates the last-served pointer and moves the FSM to GAP.
REQ-025 In GAP, int0 is 0 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 Latency: a byte pushed at edge k into an all-empty hub in IDLE raises int0 after edge k+1.
REQ-027 cpu_read_end outside PRESENT is ignored, with no pop and no state change.
REQ-028 int0, cpu_rd_data and cpu_rd_ch are registered outputs; cpu_rd_data retains its last value outside PRESENT.
REQ-029 cpu_wr=1 at edge k sets leds to cpu_wr_data, and leds_upd is 1 for the cycle after edge k.
REQ-030 Back-to-back cpu_wr cycles produce one leds update and one leds_upd cycle per write.
REQ-031 The write path is independent of the presenter FSM; simultaneous events on both paths do not interact.

Reset
REQ-032 While rst is 0, outputs are: int0=0, cpu_rd_data=0, cpu_rd_ch=0, leds=0, leds_upd=0, and in_ready all ones.
REQ-033 While rst is 0, FIFO pointers and counts are 0, the FSM is IDLE and the round-robin pointer is NCH-1.
REQ-034 Asserting rst mid-PRESENT or mid-push discards all buffered bytes immediately, without waiting for a clock edge.
REQ-035 After rst deasserts, the first active edge behaves as IDLE with empty FIFOs.

Verification
REQ-036 Push 0xA5 on channel 0 (NCH=2) -> int0=1 one cycle later with cpu_rd_data=0xA5 and cpu_rd_ch=0; cpu_read_end -> int0=0 for one cycle (GAP), FIFO empty.
REQ-037 Push 0x11 on ch0 and 0x22 on ch1 in the same cycle -> presented 0x11/ch0 then 0x22/ch1; then push ch0 and ch1 again -> ch0 served first (round robin after ch1).
REQ-038 Push 5 bytes 0x01..0x05 to ch0 with DEPTH=4 and no reads -> in_ready[0]=0 after the 4th push, the 5th byte is held by the source; draining yields 0x01..0x04 in order, then 0x05 once accepted.
REQ-039 Full FIFO with cpu_read_end and a push in the same cycle -> no push that cycle (in_ready=0); next cycle in_ready=1 and the push is accepted.
REQ-040 cpu_wr with 0x3C, then cpu_wr with 0xC3 on consecutive cycles -> leds=0x3C then 0xC3, and leds_upd is 1 for two consecutive cycles.
REQ-041 rst=0 during PRESENT with 3 bytes queued -> int0=0 immediately (no clock edge required), in_ready all ones, and no byte is presented after release until a new push.
